// File: rtl/vga_pkg.sv
// Shared definitions for the VGA scan controller.
//   - Default 640x480@60 Hz timing constants (H_*/V_* defaults, totals)
//   - 24-bit colour constants, including the eight colour-bar colours
//   - Layer-priority encoding used by the compositor
// Optional feature macro used by the top level: VGA_TEST_PATTERN_EN.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam int CNT_W = 10;

    typedef logic [23:0] rgb_t;

    localparam rgb_t COL_BLACK   = 24'h000000;
    localparam rgb_t COL_WHITE   = 24'hFFFFFF;
    localparam rgb_t COL_YELLOW  = 24'hFFFF00;
    localparam rgb_t COL_CYAN    = 24'h00FFFF;
    localparam rgb_t COL_GREEN   = 24'h00FF00;
    localparam rgb_t COL_MAGENTA = 24'hFF00FF;
    localparam rgb_t COL_RED     = 24'hFF0000;
    localparam rgb_t COL_BLUE    = 24'h0000FF;

    // Which layer wins the composite for one pixel.
    typedef enum logic [1:0] {
        LAYER_BG   = 2'd0,
        LAYER_PIPE = 2'd1,
        LAYER_BIRD = 2'd2
    } layer_e;

    // Fixed priority: bird over pipe over (always opaque) background.
    function automatic layer_e pick_layer(input logic bird_v, input logic pipe_v);
        if (bird_v)      return LAYER_BIRD;
        else if (pipe_v) return LAYER_PIPE;
        else             return LAYER_BG;
    endfunction

    // Bar colours left to right.
    function automatic rgb_t bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return COL_WHITE;
            3'd1:    return COL_YELLOW;
            3'd2:    return COL_CYAN;
            3'd3:    return COL_GREEN;
            3'd4:    return COL_MAGENTA;
            3'd5:    return COL_RED;
            3'd6:    return COL_BLUE;
            default: return COL_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// Scan timing core: horizontal/vertical counters, raw (undelayed) syncs,
// video_active and the once-per-frame tick.
// Ports:
//   clk_i, rst_ni      pixel clock, async active-low reset
//   h_cnt_o, v_cnt_o   current column / row (registers)
//   video_active_o     counters inside the visible area (combinational from counters)
//   hsync_raw_o        low while h_cnt is in the hsync window
//   vsync_raw_o        low while v_cnt is in the vsync window
//   frame_tick_o       registered, high while counters read (0, V_ACTIVE)
module vga_timing_counter
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    output logic [CNT_W-1:0] h_cnt_o,
    output logic [CNT_W-1:0] v_cnt_o,
    output logic             video_active_o,
    output logic             hsync_raw_o,
    output logic             vsync_raw_o,
    output logic             frame_tick_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS     = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS     = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_FIRST  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_LAST   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [CNT_W-1:0] TICK_LINE = CNT_W'(V_ACTIVE - 1);

    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;
    logic             tick_q, tick_d;
    logic             h_wrap;

    always_comb begin
        h_wrap = (h_q == H_LAST);
        h_d    = h_wrap ? '0 : h_q + CNT_W'(1);
        v_d    = v_q;
        if (h_wrap) begin
            v_d = (v_q == V_LAST) ? '0 : v_q + CNT_W'(1);
        end
        // Decoded one cycle early so the registered tick lines up with (0, V_ACTIVE).
        tick_d = h_wrap && (v_q == TICK_LINE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            h_q    <= '0;
            v_q    <= '0;
            tick_q <= 1'b0;
        end else begin
            h_q    <= h_d;
            v_q    <= v_d;
            tick_q <= tick_d;
        end
    end

    assign h_cnt_o        = h_q;
    assign v_cnt_o        = v_q;
    assign frame_tick_o   = tick_q;
    assign video_active_o = (h_q < H_VIS) && (v_q < V_VIS);
    assign hsync_raw_o    = !((h_q >= HS_FIRST) && (h_q <= HS_LAST));
    assign vsync_raw_o    = !((v_q >= VS_FIRST) && (v_q <= VS_LAST));

endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA scan controller: 640x480@60 Hz timing, coordinate broadcast to the
// layer renderers, two-stage alignment pipeline and fixed-priority compositor.
// Ports:
//   clk, rst_n                      pixel clock, async active-low reset
//   current_pixel_column/_row       coordinates sent to renderers
//   video_active                    coordinates are in the visible area
//   frame_tick                      one-cycle pulse at (0, V_ACTIVE)
//   bird/pipe/bg_pixel(+_valid)     renderer outputs, one cycle after coordinates
//   test_mode                       colour-bar select (only with the macro)
//   vga_rgb, vga_hsync, vga_vsync   DAC/connector outputs, 2 clocks after coordinates
// Macro VGA_TEST_PATTERN_EN: when defined, test_mode=1 replaces the composite
// with eight vertical colour bars; when undefined test_mode is ignored.
module vga_scan_ctrl
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] current_pixel_column,
    output logic [CNT_W-1:0] current_pixel_row,
    output logic             video_active,
    output logic             frame_tick,
    input  logic [23:0]      bird_pixel,
    input  logic             bird_pixel_valid,
    input  logic [23:0]      pipe_pixel,
    input  logic             pipe_pixel_valid,
    input  logic [23:0]      bg_pixel,
    input  logic             test_mode,
    output logic [23:0]      vga_rgb,
    output logic             vga_hsync,
    output logic             vga_vsync
);

    logic hsync_raw, vsync_raw;

    vga_timing_counter #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .h_cnt_o        (current_pixel_column),
        .v_cnt_o        (current_pixel_row),
        .video_active_o (video_active),
        .hsync_raw_o    (hsync_raw),
        .vsync_raw_o    (vsync_raw),
        .frame_tick_o   (frame_tick)
    );

    // Stage 1: timing delayed to line up with the renderers' registered outputs.
    logic act1_q, hs1_q, vs1_q;
    // Stage 2: final outputs.
    rgb_t rgb_q, rgb_d, comp;
    logic hs2_q, vs2_q;
    layer_e layer;

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;
    logic [CNT_W-1:0] col1_q;
    logic [2:0]       bar_idx;

    // Smallest k with col < k*BAR_W selects bar k-1; past the last edge is bar 7.
    always_comb begin
        bar_idx = 3'd7;
        for (int k = 7; k >= 1; k--) begin
            if (col1_q < CNT_W'(k * BAR_W)) bar_idx = 3'(k - 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) col1_q <= '0;
        else        col1_q <= current_pixel_column;
    end
`else
    logic unused_test_mode;
    assign unused_test_mode = test_mode;
`endif

    always_comb begin
        layer = pick_layer(bird_pixel_valid, pipe_pixel_valid);
        case (layer)
            LAYER_BIRD: comp = bird_pixel;
            LAYER_PIPE: comp = pipe_pixel;
            default:    comp = bg_pixel;
        endcase
`ifdef VGA_TEST_PATTERN_EN
        if (test_mode) comp = bar_colour(bar_idx);
`endif
        // Blanking always outputs black regardless of layer or pattern.
        rgb_d = act1_q ? comp : COL_BLACK;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act1_q <= 1'b0;
            hs1_q  <= 1'b1;
            vs1_q  <= 1'b1;
            rgb_q  <= COL_BLACK;
            hs2_q  <= 1'b1;
            vs2_q  <= 1'b1;
        end else begin
            act1_q <= video_active;
            hs1_q  <= hsync_raw;
            vs1_q  <= vsync_raw;
            rgb_q  <= rgb_d;
            hs2_q  <= hs1_q;
            vs2_q  <= vs1_q;
        end
    end

    assign vga_rgb   = rgb_q;
    assign vga_hsync = hs2_q;
    assign vga_vsync = vs2_q;

endmodule
